// File: rtl/instr_encoder.sv
// MIPS-style instruction word encoder feeding a 4-deep output FIFO.
// Delivered words carry an incrementing instruction-memory address.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [5:0]  in_funct,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_addr,
    output logic [31:0] out_data,
    input  logic        base_load,
    input  logic [7:0]  base_addr,
    output logic        err,
    output logic [7:0]  emitted
);

    typedef enum logic [3:0] {
        K_LW    = 4'd0,
        K_SW    = 4'd1,
        K_RTYPE = 4'd2,
        K_BEQ   = 4'd3,
        K_BNE   = 4'd4,
        K_ADDI  = 4'd5,
        K_ADDIU = 4'd6,
        K_ANDI  = 4'd7,
        K_ORI   = 4'd8,
        K_XORI  = 4'd9,
        K_SLTI  = 4'd10,
        K_SLTIU = 4'd11,
        K_J     = 4'd12
    } kind_e;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J
    } fmt_e;

    logic [31:0] mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  emit_q, emit_d;
    logic        err_q, err_d;

    logic [5:0]  opcode;
    fmt_e        fmt;
    logic        legal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        bad;

    always_comb begin
        opcode = 6'b000000;
        fmt    = FMT_I;
        legal  = 1'b1;
        unique case (in_kind)
            K_LW:    opcode = 6'b100011;
            K_SW:    opcode = 6'b101011;
            K_RTYPE: begin
                opcode = 6'b000000;
                fmt    = FMT_R;
            end
            K_BEQ:   opcode = 6'b000100;
            K_BNE:   opcode = 6'b000101;
            K_ADDI:  opcode = 6'b001000;
            K_ADDIU: opcode = 6'b001001;
            K_ANDI:  opcode = 6'b001100;
            K_ORI:   opcode = 6'b001101;
            K_XORI:  opcode = 6'b001110;
            K_SLTI:  opcode = 6'b001010;
            K_SLTIU: opcode = 6'b001011;
            K_J: begin
                opcode = 6'b000010;
                fmt    = FMT_J;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        word = 32'h0;
        unique case (fmt)
            FMT_R:   word = {opcode, in_rs, in_rt, in_rd,
                             5'b00000, in_funct};
            FMT_J:   word = {opcode, in_imm};
            default: word = {opcode, in_rs, in_rt, in_imm[15:0]};
        endcase
    end

    // in_ready looks only at the registered count, never at a pop
    assign in_ready  = (cnt_q < 3'd4) && !reset;
    assign out_valid = (cnt_q != 3'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign emitted   = emit_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign bad    = accept && !legal;
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        emit_d   = emit_q;
        err_d    = err_q;
        cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
            addr_d   = addr_q + 8'd1;
            emit_d   = emit_q + 8'd1;
        end
        // An empty FIFO cannot pop, so a base load never races an increment
        if (base_load && (cnt_q == 3'd0)) begin
            addr_d = base_addr;
        end
        if (bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
            addr_q   <= 8'h00;
            emit_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            emit_q   <= emit_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table plus directed FIFO,
// address, error and reset sequences checked through a scoreboard.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        err;
    logic [7:0]  emitted;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .base_load (base_load),
        .base_addr (base_addr),
        .err       (err),
        .emitted   (emitted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [25:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] sb [$];
    logic [7:0]  exp_addr;
    logic [7:0]  exp_emit;
    logic        exp_err;
    int          checks;
    int          errors;

    logic        pv, pr, prst;
    logic [31:0] pd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v, input bit legal,
                        input bit bl, input logic [7:0] ba);
        int n;
        in_valid  = 1'b1;
        in_kind   = v.kind;
        in_rs     = v.rs;
        in_rt     = v.rt;
        in_rd     = v.rd;
        in_funct  = v.funct;
        in_imm    = v.imm;
        base_load = bl;
        base_addr = ba;
        #0;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=0 required=1");
        end else begin
            if (bl && sb.size() == 0) exp_addr = ba;
            if (legal) sb.push_back(v.exp);
            else exp_err = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        base_load = 1'b0;
    endtask

    task automatic base(input logic [7:0] ba);
        base_load = 1'b1;
        base_addr = ba;
        if (sb.size() == 0) exp_addr = ba;
        tick();
        base_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0",
                     sb.size());
        end
        tick();
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (!prst && pv && !pr) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", out_data, pd);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual=%h required=none",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_addr", {24'b0, out_addr}, {24'b0, exp_addr});
                    exp_addr++;
                    exp_emit++;
                end
            end
        end
        pv   = out_valid;
        pr   = out_ready;
        pd   = out_data;
        prst = reset;
    end

    initial begin
        vec_t bad;
        checks    = 0;
        errors    = 0;
        exp_addr  = 8'h00;
        exp_emit  = 8'h00;
        exp_err   = 1'b0;
        prst      = 1'b1;
        pv        = 1'b0;
        pr        = 1'b0;
        pd        = 32'h0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_kind   = 4'd0;
        in_rs     = 5'd0;
        in_rt     = 5'd0;
        in_rd     = 5'd0;
        in_funct  = 6'd0;
        in_imm    = 26'd0;
        out_ready = 1'b0;
        base_load = 1'b0;
        base_addr = 8'h00;

        tbl[0]  = '{4'd5,  5'd1,  5'd2,  5'd0,  6'd0,  26'h0000005, 32'h20220005};
        tbl[1]  = '{4'd0,  5'd29, 5'd8,  5'd0,  6'd0,  26'h0000004, 32'h8FA80004};
        tbl[2]  = '{4'd2,  5'd1,  5'd2,  5'd3,  6'h20, 26'h0000000, 32'h00221820};
        tbl[3]  = '{4'd12, 5'd0,  5'd0,  5'd0,  6'd0,  26'h0000010, 32'h08000010};
        tbl[4]  = '{4'd4,  5'd4,  5'd5,  5'd0,  6'd0,  26'h000FFFE, 32'h1485FFFE};
        tbl[5]  = '{4'd1,  5'd29, 5'd9,  5'd7,  6'h3F, 26'h0000008, 32'hAFA90008};
        tbl[6]  = '{4'd3,  5'd4,  5'd5,  5'd0,  6'd0,  26'h0000010, 32'h10850010};
        tbl[7]  = '{4'd6,  5'd3,  5'd4,  5'd31, 6'h15, 26'h3FF1234, 32'h24641234};
        tbl[8]  = '{4'd7,  5'd5,  5'd6,  5'd0,  6'd0,  26'h00000FF, 32'h30A600FF};
        tbl[9]  = '{4'd8,  5'd7,  5'd8,  5'd0,  6'd0,  26'h000ABCD, 32'h34E8ABCD};
        tbl[10] = '{4'd9,  5'd31, 5'd31, 5'd0,  6'd0,  26'h000FFFF, 32'h3BFFFFFF};
        tbl[11] = '{4'd10, 5'd0,  5'd1,  5'd0,  6'd0,  26'h0008000, 32'h28018000};
        tbl[12] = '{4'd11, 5'd2,  5'd3,  5'd0,  6'd0,  26'h0000001, 32'h2C430001};
        tbl[13] = '{4'd12, 5'd31, 5'd31, 5'd31, 6'h3F, 26'h3FFFFFF, 32'h0BFFFFFF};
        bad     = '{4'd14, 5'd1,  5'd2,  5'd3,  6'd1,  26'h0000001, 32'h0};

        tick();
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_emitted", {24'b0, emitted}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", {24'b0, out_addr}, 32'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);

        out_ready = 1'b1;
        base(8'h10);
        push(tbl[0], 1'b1, 1'b0, 8'h00);
        push(tbl[1], 1'b1, 1'b0, 8'h00);
        drain();
        chk("emitted_two", {24'b0, emitted}, 32'd2);
        chk("addr_after_two", {24'b0, out_addr}, 32'h12);

        for (int i = 0; i < 14; i++) begin
            push(tbl[i], 1'b1, 1'b0, 8'h00);
        end
        drain();
        chk("emitted_table", {24'b0, emitted}, {24'b0, exp_emit});

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(tbl[i], 1'b1, 1'b0, 8'h00);
        end
        in_valid = 1'b1;
        in_kind  = tbl[4].kind;
        in_rs    = tbl[4].rs;
        in_rt    = tbl[4].rt;
        in_imm   = tbl[4].imm;
        for (int i = 0; i < 3; i++) begin
            chk("full_in_ready", {31'b0, in_ready}, 32'd0);
            chk("full_head", out_data, tbl[0].exp);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("pop_no_ready", {31'b0, in_ready}, 32'd0);
        push(tbl[4], 1'b1, 1'b0, 8'h00);
        drain();

        push(bad, 1'b0, 1'b0, 8'h00);
        tick();
        chk("err_set", {31'b0, err}, {31'b0, exp_err});
        chk("err_no_valid", {31'b0, out_valid}, 32'd0);
        chk("err_emitted", {24'b0, emitted}, {24'b0, exp_emit});
        push(tbl[9], 1'b1, 1'b0, 8'h00);
        drain();
        chk("err_sticky", {31'b0, err}, 32'd1);

        out_ready = 1'b0;
        base(8'hFF);
        chk("base_ff", {24'b0, out_addr}, 32'hFF);
        push(tbl[5], 1'b1, 1'b0, 8'h00);
        push(tbl[6], 1'b1, 1'b0, 8'h00);
        base(8'h40);
        chk("base_ignored", {24'b0, out_addr}, 32'hFF);
        out_ready = 1'b1;
        drain();
        chk("addr_wrap", {24'b0, out_addr}, 32'h01);

        push(tbl[7], 1'b1, 1'b1, 8'h80);
        drain();
        chk("addr_base_push", {24'b0, out_addr}, 32'h81);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(tbl[i + 10], 1'b1, 1'b0, 8'h00);
        end
        reset = 1'b1;
        #1;
        chk("rst_in_ready2", {31'b0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        exp_addr = 8'h00;
        exp_emit = 8'h00;
        exp_err  = 1'b0;
        #1;
        chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_emitted", {24'b0, emitted}, 32'd0);
        chk("rst2_err", {31'b0, err}, 32'd0);
        chk("rst2_addr", {24'b0, out_addr}, 32'd0);
        out_ready = 1'b1;
        push(tbl[2], 1'b1, 1'b0, 8'h00);
        drain();
        chk("post_rst_emitted", {24'b0, emitted}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
